// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared types and constants for the UART transmit scheduler.
// Holds the scheduler state encoding, the two acknowledge bytes, the rate
// codes understood by the transmitter and two small helper functions.
package tx_sched_pkg;

    // Scheduler states, in the order a byte moves through them.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Acknowledge message sent when a rate-control session finishes: "OK".
    localparam logic [7:0] ACK_BYTE0 = 8'h4F;
    localparam logic [7:0] ACK_BYTE1 = 8'h4B;

    // Rate codes applied to the transmitter.
    localparam logic [1:0] RATE_1 = 2'b00;
    localparam logic [1:0] RATE_5 = 2'b01;
    localparam logic [1:0] RATE_A = 2'b10;

    // Maps a requested rate code onto a legal one; the unused code 11
    // falls back to the default rate.
    function automatic logic [1:0] rate_map(input logic [1:0] code);
        case (code)
            RATE_5:  return RATE_5;
            RATE_A:  return RATE_A;
            default: return RATE_1;
        endcase
    endfunction

    // Selects the acknowledge byte for a given position in the message.
    function automatic logic [7:0] ack_byte(input logic idx);
        return idx ? ACK_BYTE1 : ACK_BYTE0;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: DEPTH-entry synchronous byte FIFO for the transmit scheduler.
// A push into a full FIFO and a pop from an empty FIFO are ignored here;
// the caller decides whether a rejected push is reported. Flush wins over
// both push and pop in the same cycle. The head entry is read
// combinationally so the caller can register it in the same cycle it pops.
module tx_fifo
    import tx_sched_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] data,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Status comes straight from the registered count.
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// tx_scheduler: sequences the single UART transmitter behind the
// mode-control decoder. Data bytes are buffered in tx_fifo, a two-byte
// acknowledge ("OK") is inserted when a rate session finishes, and new rate
// codes reach the transmitter only while no byte is in flight.
//
// Build option: define TX_ACK_EN to include the acknowledge logic. Without
// it iFINISH is ignored and only FIFO data is transmitted; ports are the
// same in both builds.
//
// Handshake with the transmitter: oTX_START is a one-cycle pulse with
// oTX_DATA valid in that same cycle; the transmitter must raise iTX_BUSY no
// later than the following cycle and hold it until the byte is shifted out.
// A new start is never issued while iTX_BUSY is high or iTX_RATE_STATE is
// high. state_dbg mirrors the FSM state for observation.
module tx_scheduler
    import tx_sched_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] iData,
    input  logic       iWRen,
    input  logic       iCLEAN,
    input  logic       iFINISH,
    input  logic [1:0] irate_control,
    input  logic       iTX_RATE_STATE,
    input  logic       iTX_BUSY,
    output logic [7:0] oTX_DATA,
    output logic       oTX_START,
    output logic [1:0] orate_control,
    output logic       oFULL,
    output logic       oEMPTY,
    output logic       oDROP,
    output logic [1:0] state_dbg
);

    state_t     state;
    state_t     state_next;
    logic       start_ack;
    logic       start_fifo;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       ack_req;
    logic       ack_idx;

    assign state_dbg = state;
    assign oFULL     = fifo_full;
    assign oEMPTY    = fifo_empty;

    // The head is popped on the same edge that loads oTX_DATA, so the
    // FIFO status already reflects the pop while oTX_START is high.
    tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (iWRen && !iCLEAN),
        .pop   (start_fifo),
        .flush (iCLEAN),
        .data  (iData),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef TX_ACK_EN
    logic ack_pending;

    assign ack_req = ack_pending;

    // Acknowledge tracking: one message outstanding at most; each ack start
    // advances the byte index and the second one retires the message.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_pending <= 1'b0;
            ack_idx     <= 1'b0;
        end else if (iCLEAN) begin
            ack_pending <= 1'b0;
            ack_idx     <= 1'b0;
        end else if (start_ack) begin
            if (ack_idx) begin
                ack_pending <= 1'b0;
                ack_idx     <= 1'b0;
            end else begin
                ack_idx <= 1'b1;
            end
        end else if (iFINISH && !ack_pending) begin
            ack_pending <= 1'b1;
            ack_idx     <= 1'b0;
        end
    end
`else
    logic unused_finish;

    // No acknowledge path: the request never fires and iFINISH is sunk.
    assign ack_req       = 1'b0;
    assign ack_idx       = 1'b0;
    assign unused_finish = iFINISH;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and source selection. A flush in the decision cycle
    // suppresses the start so a flushed entry is never transmitted.
    always_comb begin
        state_next = state;
        start_ack  = 1'b0;
        start_fifo = 1'b0;
        case (state)
            IDLE: begin
                if (!iTX_RATE_STATE && !iCLEAN) begin
                    if (ack_req) begin
                        start_ack  = 1'b1;
                        state_next = START;
                    end else if (!fifo_empty) begin
                        start_fifo = 1'b1;
                        state_next = START;
                    end
                end
            end
            START:   state_next = GUARD;
            GUARD:   state_next = WAIT;
            WAIT: begin
                if (!iTX_BUSY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered transmitter outputs: start pulse and byte are loaded on the
    // edge entering START; the rate follows the request only while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oTX_START     <= 1'b0;
            oTX_DATA      <= 8'h00;
            orate_control <= RATE_1;
            oDROP         <= 1'b0;
        end else begin
            oTX_START <= start_ack || start_fifo;
            if (start_ack) begin
                oTX_DATA <= ack_byte(ack_idx);
            end else if (start_fifo) begin
                oTX_DATA <= fifo_head;
            end
            if (state == IDLE) begin
                orate_control <= rate_map(irate_control);
            end
            oDROP <= iWRen && fifo_full && !iCLEAN;
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: directed bench for tx_scheduler with a transaction-level
// reference model (byte queue plus acknowledge flag) checked every cycle.
module tb_tx_scheduler;

    localparam int DEPTH  = 16;
    localparam int TX_LEN = 3;

`ifdef TX_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iWRen = 1'b0;
    logic       iCLEAN = 1'b0;
    logic       iFINISH = 1'b0;
    logic [1:0] irate_control = 2'b00;
    logic       iTX_RATE_STATE = 1'b0;
    logic       iTX_BUSY = 1'b0;
    logic [7:0] oTX_DATA;
    logic       oTX_START;
    logic [1:0] orate_control;
    logic       oFULL;
    logic       oEMPTY;
    logic       oDROP;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    tx_scheduler #(
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .iData          (iData),
        .iWRen          (iWRen),
        .iCLEAN         (iCLEAN),
        .iFINISH        (iFINISH),
        .irate_control  (irate_control),
        .iTX_RATE_STATE (iTX_RATE_STATE),
        .iTX_BUSY       (iTX_BUSY),
        .oTX_DATA       (oTX_DATA),
        .oTX_START      (oTX_START),
        .orate_control  (orate_control),
        .oFULL          (oFULL),
        .oEMPTY         (oEMPTY),
        .oDROP          (oDROP),
        .state_dbg      (state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transmitter stand-in ----------------
    // Busy rises in the start cycle and stays high for TX_LEN negedges.
    int busy_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            busy_cnt = 0;
        end else if (oTX_START) begin
            busy_cnt = TX_LEN;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        iTX_BUSY = (busy_cnt > 0);
    end

    // ---------------- reference model + scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] sent_q[$];
    int         start_cyc[$];
    bit         m_pending = 1'b0;
    bit         m_idx = 1'b0;
    int         cyc = 0;
    bit         full_pre;
    bit         pending_pre;
    bit         drop_exp;
    bit         have_src;
    logic [7:0] exp_b;
    logic       prev_start = 1'b0;
    logic       prev_busy = 1'b0;
    logic [1:0] prev_rate = 2'b00;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!reset) begin
            exp_q.delete();
            m_pending  = 1'b0;
            m_idx      = 1'b0;
            prev_start = 1'b0;
            prev_busy  = 1'b0;
            prev_rate  = 2'b00;
        end else begin
            full_pre    = (exp_q.size() == DEPTH);
            pending_pre = m_pending;
            drop_exp    = 1'b0;
            if (oTX_START) begin
                have_src = 1'b1;
                exp_b    = 8'h00;
                if (m_pending) begin
                    exp_b = m_idx ? 8'h4B : 8'h4F;
                    if (m_idx) begin
                        m_pending = 1'b0;
                        m_idx     = 1'b0;
                    end else begin
                        m_idx = 1'b1;
                    end
                end else if (exp_q.size() > 0) begin
                    exp_b = exp_q.pop_front();
                end else begin
                    have_src = 1'b0;
                end
                check("start_has_source", 32'(have_src), 32'd1);
                check("tx_data", 32'(oTX_DATA), 32'(exp_b));
                sent_q.push_back(oTX_DATA);
                start_cyc.push_back(cyc);
            end
            if (iCLEAN) begin
                exp_q.delete();
                m_pending = 1'b0;
                m_idx     = 1'b0;
            end else begin
                if (iWRen) begin
                    if (full_pre) drop_exp = 1'b1;
                    else exp_q.push_back(iData);
                end
                if (ACK_EN && iFINISH && !pending_pre) begin
                    m_pending = 1'b1;
                    m_idx     = 1'b0;
                end
            end
            check("empty", 32'(oEMPTY), 32'(exp_q.size() == 0));
            check("full", 32'(oFULL), 32'(exp_q.size() == DEPTH));
            check("drop", 32'(oDROP), 32'(drop_exp));
            if (prev_start || prev_busy) begin
                check("rate_hold_in_flight", 32'(orate_control), 32'(prev_rate));
            end
            prev_start = oTX_START;
            prev_busy  = iTX_BUSY;
            prev_rate  = orate_control;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [7:0] b);
        iData = b;
        iWRen = 1'b1;
        @(negedge clk);
        iWRen = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (oTX_START !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_start_seen"}, 32'(oTX_START), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    int         base;
    int         n3;
    logic [7:0] seq3[4];
    int         n6;

    initial begin
        // Reset values.
        idle(3);
        check("rst_start", 32'(oTX_START), 32'd0);
        check("rst_data", 32'(oTX_DATA), 32'h00);
        check("rst_rate", 32'(orate_control), 32'd0);
        check("rst_drop", 32'(oDROP), 32'd0);
        check("rst_empty", 32'(oEMPTY), 32'd1);
        check("rst_full", 32'(oFULL), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b1;
        idle(2);

        // Latency: push in cycle N, start in cycle N+2.
        push_byte(8'h41);
        check("lat_n1_start", 32'(oTX_START), 32'd0);
        check("lat_n1_empty", 32'(oEMPTY), 32'd0);
        idle(1);
        check("lat_n2_start", 32'(oTX_START), 32'd1);
        check("lat_n2_data", 32'(oTX_DATA), 32'h41);
        check("lat_n2_empty", 32'(oEMPTY), 32'd1);
        idle(10);

        // Fill, overflow, drop even while popping, then drain 16 in order.
        iTX_RATE_STATE = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        check("fill_full", 32'(oFULL), 32'd1);
        check("fill_drop_none", 32'(oDROP), 32'd0);
        push_byte(8'h7F);
        check("fill_drop17", 32'(oDROP), 32'd1);
        idle(1);
        check("fill_drop_pulse", 32'(oDROP), 32'd0);
        base = sent_q.size();
        iTX_RATE_STATE = 1'b0;
        push_byte(8'hEE);
        check("pop_cycle_drop", 32'(oDROP), 32'd1);
        check("pop_cycle_full", 32'(oFULL), 32'd0);
        idle(100);
        check("fill_sent_count", 32'(sent_q.size() - base), 32'd16);
        if (sent_q.size() >= base + 16) begin
            check("fill_first", 32'(sent_q[base]), 32'h10);
            check("fill_last", 32'(sent_q[base+15]), 32'h1F);
            check("gap_first", 32'(start_cyc[base+1] - start_cyc[base]), 32'd5);
            check("gap_last", 32'(start_cyc[base+15] - start_cyc[base+14]), 32'd5);
        end
        check("fill_drained", 32'(oEMPTY), 32'd1);

        // Acknowledge inserted between queued data bytes.
`ifdef TX_ACK_EN
        n3 = 4;
        seq3[0] = 8'hA1; seq3[1] = 8'h4F; seq3[2] = 8'h4B; seq3[3] = 8'hA2;
`else
        n3 = 2;
        seq3[0] = 8'hA1; seq3[1] = 8'hA2; seq3[2] = 8'h00; seq3[3] = 8'h00;
`endif
        base = sent_q.size();
        iTX_RATE_STATE = 1'b1;
        push_byte(8'hA1);
        push_byte(8'hA2);
        iTX_RATE_STATE = 1'b0;
        wait_start("ack_b1");
        iFINISH = 1'b1;
        idle(1);
        iFINISH = 1'b0;
        wait_start("ack_second");
        iFINISH = 1'b1;
        idle(1);
        iFINISH = 1'b0;
        idle(40);
        check("ack_count", 32'(sent_q.size() - base), 32'(n3));
        for (int i = 0; i < n3; i++) begin
            if (sent_q.size() > base + i) check("ack_seq", 32'(sent_q[base+i]), 32'(seq3[i]));
        end

        // Rate change held while busy, applied once idle.
        push_byte(8'h61);
        wait_start("rate");
        idle(1);
        irate_control = 2'b10;
        idle(1);
        check("rate_busy_a", 32'(orate_control), 32'd0);
        idle(1);
        check("rate_busy_b", 32'(orate_control), 32'd0);
        idle(2);
        check("rate_applied", 32'(orate_control), 32'd2);
        irate_control = 2'b11;
        idle(2);
        check("rate_11_maps", 32'(orate_control), 32'd0);
        irate_control = 2'b01;
        idle(2);
        check("rate_01", 32'(orate_control), 32'd1);
        irate_control = 2'b00;
        idle(4);

        // Flush during WAIT of the first of five bytes.
        base = sent_q.size();
        iTX_RATE_STATE = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'hC1 + 8'(i));
        iTX_RATE_STATE = 1'b0;
        wait_start("clean");
        idle(2);
        iCLEAN = 1'b1;
        idle(1);
        iCLEAN = 1'b0;
        check("clean_empty", 32'(oEMPTY), 32'd1);
        idle(30);
        check("clean_sent", 32'(sent_q.size() - base), 32'd1);
        if (sent_q.size() > base) check("clean_first", 32'(sent_q[base]), 32'hC1);
        check("clean_empty_end", 32'(oEMPTY), 32'd1);

        // iFINISH with nothing queued.
        n6 = ACK_EN ? 2 : 0;
        base = sent_q.size();
        iFINISH = 1'b1;
        idle(1);
        iFINISH = 1'b0;
        idle(25);
        check("finish_empty_count", 32'(sent_q.size() - base), 32'(n6));

        // Reset mid-operation clears the queue immediately.
        base = sent_q.size();
        iTX_RATE_STATE = 1'b1;
        push_byte(8'h91);
        push_byte(8'h92);
        check("midrst_pre_empty", 32'(oEMPTY), 32'd0);
        reset = 1'b0;
        idle(1);
        check("midrst_empty", 32'(oEMPTY), 32'd1);
        check("midrst_start", 32'(oTX_START), 32'd0);
        reset = 1'b1;
        iTX_RATE_STATE = 1'b0;
        idle(15);
        check("midrst_no_tx", 32'(sent_q.size() - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
